board_renderer: RTL
===================

# board_renderer

Reads the 15×8 `current_board` playfield produced by the board logic and draws it into the 16×16 green/red LED pixel arrays that drive the display. It samples the board on a frame request and builds the image one row per clock in a back buffer. The image includes the fixed well walls and floor, and full rows blink red. On completion the whole frame is committed atomically to the outputs, so the display never shows a half-drawn frame.

## Interface
Parameters:
- `BLINK_FRAMES`, default 8: number of committed frames per blink phase. Legal range is 1..255.

Ports:
- `clk`: input, 1 bit. Single clock domain.
- `reset`: input, 1 bit. Asynchronous, active-high; clears all state.
- `frame_req`: input, 1 bit. Requests one render pass. Sampled only in IDLE.
- `current_board`: input, [14:0][7:0]. Playfield. Index 0 is the top row; bit 7 is the leftmost column.
- `busy`: output, 1 bit. High while in RENDER or COMMIT.
- `frame_done`: output, 1 bit. One-cycle pulse after outputs update.
- `GrnPixels`: output, [15:0][15:0]. Green LED image. Index 0 is the top row.
- `RedPixels`: output, [15:0][15:0]. Red LED image.
- `full_rows`: output, [14:0]. Bit r is set when snapshot row r == 8'hFF. Updated at commit.

## Operation
- States: IDLE, RENDER, COMMIT.
- IDLE:
  - On `frame_req`=1: latch `current_board` into `snap`, latch `blink_on` into `phase`, set `row`=0, go to RENDER.
  - Otherwise stay in IDLE.
- RENDER: each cycle write back-buffer row `row`, then increment `row`. After `row`==15 is written, go to COMMIT.
- Row composition for r = 0..14 (green):
  - bits 15:11 = 0, bit 10 = 1, bits 9:2 = `snap[r]`, bit 1 = 1, bit 0 = 0.
- Red for r = 0..14:
  - If `snap[r]`==8'hFF and `phase`==1: red bits 9:2 = 8'hFF, and green bits 9:2 are forced to 0 for that row.
  - Otherwise the red row is all zero.
- Row 15 (floor):
  - Green = 16'b0000011111111110.
  - Red = 0.
- COMMIT:
  - Copy the green and red back buffers to `GrnPixels` and `RedPixels`.
  - Set `full_rows` from the full-row flags of `snap`.
  - Advance the blink counter.
  - Go to IDLE with `frame_done` registered high for exactly one cycle.
- Blink counter:
  - `blink_cnt` counts commits from 0 to BLINK_FRAMES-1.
  - On the commit where `blink_cnt`==BLINK_FRAMES-1, it wraps to 0 and `blink_on` toggles.
  - With BLINK_FRAMES=1, `blink_on` toggles on every commit.
- `frame_req` while `busy`=1 is ignored and not queued.
- Changes to `current_board` after the latch have no effect on the frame in progress.

## Timing
- Reset values:
  - `GrnPixels`, `RedPixels`, `full_rows`: all 0.
  - `busy`=0, `frame_done`=0.
  - State IDLE, `row`=0, `blink_cnt`=0, `blink_on`=0.
- Edge numbering: `frame_req` is sampled at edge E0.
  - `busy` is high from after E0 through the cycle after E17.
  - Back-buffer row r is written at edge E(r+1), for r = 0..15.
  - COMMIT occupies the cycle after E16.
  - Outputs update and `frame_done` rises at E17. `frame_done` and `busy` fall at E18.
  - Request-to-outputs latency is 17 cycles.
- Back-to-back frames: `frame_req` held high yields one frame every 18 cycles, since IDLE is occupied for one cycle at E18 and the next latch happens at E18.
- Reset asserted mid-RENDER or in COMMIT:
  - Immediate return to IDLE with all outputs cleared.
  - The partial frame is never committed and the blink counter does not advance.
- Outputs are stable between commits. `GrnPixels` and `RedPixels` change only at a COMMIT edge or on reset.

## Test plan
- Reset then empty board with one `frame_req`:
  - After 17 cycles, `GrnPixels[0..14]` = 16'b0000010000000010 and `GrnPixels[15]` = 16'b0000011111111110.
  - `RedPixels` = 0, `full_rows` = 0.
  - `frame_done` is a single one-cycle pulse and `busy` is high for exactly 18 cycles.
- Square at rows 13 and 14 (each row 8'b00011000):
  - `GrnPixels[13]` and `GrnPixels[14]` = 16'b0000010001100010.
  - All other playfield rows show walls only.
- Row 14 = 8'hFF, BLINK_FRAMES=1, 2 frames:
  - Frame 1 (phase 0): `GrnPixels[14]` = 16'b0000011111111110, `RedPixels[14]` = 0.
  - Frame 2 (phase 1): `GrnPixels[14]` = 16'b0000010000000010, `RedPixels[14]` = 16'b0000001111111100.
  - `full_rows` = 15'h4000 after both frames.
- Snapshot and ignore rules:
  - Change `current_board` and pulse `frame_req` at E5 during a render.
  - The committed frame shows the board latched at E0, no second frame starts, and `frame_done` pulses once.
- Assert `reset` at E10 of a render:
  - Outputs go to 0 immediately and `frame_done` never pulses.
  - The next request after reset renders correctly with `blink_on`=0.
- BLINK_FRAMES=8 with a full row, 16 consecutive frames:
  - Red is absent in frames 1-8 and present in frames 9-16.

Source files
------------

// File: rtl/board_renderer.sv
// Renders the 15x8 playfield plus well walls and floor into 16x16 green/red LED images.
// A back buffer is filled one row per clock and committed to the outputs in a single edge.
module board_renderer #(
   parameter int unsigned BLINK_FRAMES = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                frame_req,
   input  logic [14:0][7:0]    current_board,
   output logic                busy,
   output logic                frame_done,
   output logic [15:0][15:0]   GrnPixels,
   output logic [15:0][15:0]   RedPixels,
   output logic [14:0]         full_rows
);

   localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);

   typedef enum logic [1:0] {IDLE, RENDER, COMMIT} state_t;

   state_t            state, state_next;
   logic [15:0][7:0]  snap;
   logic              phase;
   logic [3:0]        row;
   logic [7:0]        blink_cnt;
   logic              blink_on;
   logic [15:0][15:0] grn_buf, red_buf;
   logic [15:0]       grn_row, red_row;
   logic [14:0]       snap_full;
   logic              row_blink;

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (frame_req) state_next = RENDER;
         RENDER:  if (row == 4'd15) state_next = COMMIT;
         COMMIT:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      snap_full = '0;
      for (int unsigned i = 0; i < 15; i++) begin
         snap_full[i] = (snap[i] == 8'hFF);
      end
   end

   // Snapshot slot 15 is always zero, so indexing by row never leaves the array.
   always_comb begin
      grn_row   = '0;
      red_row   = '0;
      row_blink = (snap[row] == 8'hFF) && phase;
      if (row == 4'd15) begin
         grn_row = 16'b0000011111111110;
      end else begin
         grn_row = {5'b00000, 1'b1, (row_blink ? 8'h00 : snap[row]), 1'b1, 1'b0};
         red_row = {6'b000000, (row_blink ? 8'hFF : 8'h00), 2'b00};
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         snap       <= '0;
         phase      <= 1'b0;
         row        <= '0;
         blink_cnt  <= '0;
         blink_on   <= 1'b0;
         grn_buf    <= '0;
         red_buf    <= '0;
         GrnPixels  <= '0;
         RedPixels  <= '0;
         full_rows  <= '0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         state      <= state_next;
         // busy stays high through the IDLE cycle that carries frame_done.
         busy       <= (state != IDLE) || frame_req;
         frame_done <= (state == COMMIT);
         case (state)
            IDLE: begin
               if (frame_req) begin
                  snap  <= {8'h00, current_board};
                  phase <= blink_on;
                  row   <= '0;
               end
            end
            RENDER: begin
               grn_buf[row] <= grn_row;
               red_buf[row] <= red_row;
               row          <= row + 4'd1;
            end
            COMMIT: begin
               GrnPixels <= grn_buf;
               RedPixels <= red_buf;
               full_rows <= snap_full;
               if (blink_cnt == BLINK_LAST) begin
                  blink_cnt <= '0;
                  blink_on  <= ~blink_on;
               end else begin
                  blink_cnt <= blink_cnt + 8'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
